// File: rtl/i2s_rx_pkg.sv
// Shared constants for the I2S receive path: default sample width,
// channel-select encodings and FSM state codes.
package i2s_rx_pkg;

   localparam int DATA_W_DEF = 24;

   localparam int CH_LEFT  = 0;
   localparam int CH_RIGHT = 1;
   localparam int CH_MIX   = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ALIGN = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/i2s_rx_sampler_sync_edge_det.sv
// Two-flop synchroniser followed by one alignment stage and a registered rising-edge flag.
// sync and rise are aligned, so lanes sharing this module keep equal latency.
module sync_edge_det (
   input  logic audio_clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise
);

   logic [2:0] stage;
   logic       rise_q;

   always_ff @(posedge audio_clk or negedge rst_n) begin
      if (!rst_n) begin
         stage  <= 3'b000;
         rise_q <= 1'b0;
      end else begin
         stage  <= {stage[1:0], din};
         rise_q <= stage[1] & ~stage[2];
      end
   end

   assign sync = stage[2];
   assign rise = rise_q;

endmodule

// File: rtl/i2s_rx_sampler.sv
// I2S receiver: oversamples bclk/lrck/sdata in audio_clk, deserialises MSB-first
// words and emits left, right or the L/R average as a registered one-cycle pulse.
module i2s_rx_sampler
   import i2s_rx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CH_SEL = CH_LEFT
) (
   input  logic              audio_clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              i2s_bclk,
   input  logic              i2s_lrck,
   input  logic              i2s_sdata,
   output logic              audio_valid,
   output logic [DATA_W-1:0] audio_data,
   output logic              frame_err
);

   localparam int CW = $clog2(DATA_W + 1);

   logic [2:0] raw_in;
   logic [2:0] sync_v;
   logic [2:0] rise_v;

   assign raw_in = {i2s_sdata, i2s_lrck, i2s_bclk};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         sync_edge_det u_sync (
            .audio_clk (audio_clk),
            .rst_n     (rst_n),
            .din       (raw_in[gi]),
            .sync      (sync_v[gi]),
            .rise      (rise_v[gi])
         );
      end
   endgenerate

   logic bit_ev;
   logic lrck_s;
   logic sdata_s;

   assign bit_ev  = rise_v[0];
   assign lrck_s  = sync_v[1];
   assign sdata_s = sync_v[2];

   logic [1:0]        state;
   logic [CW-1:0]     bit_cnt;
   logic              cur_ch;
   logic              lrck_prev;
   logic              left_ok;
   logic              first_word;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] left_q;

   logic              boundary;
   logic [DATA_W-1:0] shift_next;
   logic [DATA_W:0]   mix_sum;
   logic              emit;
   logic [DATA_W-1:0] sample;

   assign boundary   = bit_ev && (lrck_s != lrck_prev);
   assign shift_next = {shift_reg[DATA_W-2:0], sdata_s};
   // Sign-extended sum; bits [DATA_W:1] are the floor-halved average.
   assign mix_sum    = {left_q[DATA_W-1], left_q} + {shift_next[DATA_W-1], shift_next};

   always_comb begin
      emit   = 1'b0;
      sample = shift_next;
      if (CH_SEL == CH_MIX) begin
         emit   = cur_ch & left_ok;
         sample = mix_sum[DATA_W:1];
      end else if (CH_SEL == CH_RIGHT) begin
         emit = cur_ch;
      end else begin
         emit = ~cur_ch;
      end
   end

   always_ff @(posedge audio_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         cur_ch      <= 1'b0;
         lrck_prev   <= 1'b0;
         left_ok     <= 1'b0;
         first_word  <= 1'b0;
         shift_reg   <= '0;
         left_q      <= '0;
         audio_valid <= 1'b0;
         audio_data  <= '0;
         frame_err   <= 1'b0;
      end else begin
         audio_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (bit_ev) begin
            lrck_prev <= lrck_s;
         end
         if (!enable) begin
            state   <= ST_ALIGN;
            left_ok <= 1'b0;
            bit_cnt <= '0;
         end else if (bit_ev) begin
            if (boundary) begin
               // SHIFT only ever holds an incomplete word, so a boundary here is a short word.
               if (state == ST_SHIFT) begin
                  frame_err <= ~first_word;
                  if (cur_ch) begin
                     left_ok <= 1'b0;
                  end
               end
               first_word <= (state == ST_IDLE) || (state == ST_ALIGN);
               state      <= ST_SHIFT;
               bit_cnt    <= '0;
               cur_ch     <= lrck_s;
            end else if (state == ST_SHIFT) begin
               shift_reg <= shift_next;
               bit_cnt   <= bit_cnt + 1'b1;
               if (bit_cnt == CW'(DATA_W - 1)) begin
                  state <= ST_HOLD;
                  if (!cur_ch) begin
                     left_q  <= shift_next;
                     left_ok <= 1'b1;
                  end else begin
                     left_ok <= 1'b0;
                  end
                  if (emit) begin
                     audio_valid <= 1'b1;
                     audio_data  <= sample;
                  end
               end
            end
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{sync_v[0], rise_v[2:1], mix_sum[0]};

endmodule

// File: tb/tb_i2s_rx_sampler.sv
// Drives one I2S stream into left, right and mix receivers in parallel; a slot-level
// reference model queues expected samples/frame errors with their arrival times.
`timescale 1ns/1ps
module tb_i2s_rx_sampler;

   localparam int  DW        = 24;
   localparam time CLK_HALF  = 50;
   localparam time BCLK_HALF = 200;
   localparam time LAT       = 400;

   localparam int EV_NONE = 0;
   localparam int EV_DIS  = 1;
   localparam int EV_EN   = 2;
   localparam int EV_RST  = 3;

   logic audio_clk = 1'b0;
   logic rst_n     = 1'b0;
   logic enable    = 1'b0;
   logic bclk      = 1'b0;
   logic lrck      = 1'b0;
   logic sdata     = 1'b0;

   logic [2:0]    valid;
   logic [2:0]    ferr;
   logic [DW-1:0] data_o [3];

   always #CLK_HALF audio_clk = ~audio_clk;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         i2s_rx_sampler #(.DATA_W(DW), .CH_SEL(gi)) u_dut (
            .audio_clk   (audio_clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .i2s_bclk    (bclk),
            .i2s_lrck    (lrck),
            .i2s_sdata   (sdata),
            .audio_valid (valid[gi]),
            .audio_data  (data_o[gi]),
            .frame_err   (ferr[gi])
         );
      end
   endgenerate

   typedef struct {
      logic [DW-1:0] d;
      time           t;
   } exp_t;

   exp_t exp_q [3][$];
   time  ferr_q [$];

   int checks = 0;
   int errors = 0;

   // Reference model state, tracked per slot rather than per clock.
   logic          m_prev_ch, m_en, m_cap, m_cap_ch, m_first_cap, m_synced, m_left_ok;
   logic [DW-1:0] m_left_q;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mix_ref(input logic [DW-1:0] l, input logic [DW-1:0] r);
      int s;
      s = (int'($signed(l)) + int'($signed(r))) >>> 1;
      return s[DW-1:0];
   endfunction

   task automatic push_exp(input int idx, input logic [DW-1:0] d, input time t);
      exp_t e;
      e.d = d;
      e.t = t;
      exp_q[idx].push_back(e);
   endtask

   // One lrck slot: period 0 is the delay-slot boundary bit, periods 1..DW carry the word.
   task automatic send_slot(input logic ch, input int nbits, input logic [DW-1:0] d,
                            input int ev, input int ev_k);
      time  tr;
      time  used;
      logic started;
      started = 1'b0;
      for (int p = 0; p <= nbits; p++) begin
         used  = 0;
         bclk  = 1'b0;
         lrck  = ch;
         sdata = (p >= 1 && p <= DW) ? d[DW-p] : 1'($urandom_range(0, 1));
         if (ev != EV_NONE && p == ev_k) begin
            if (ev == EV_DIS) begin
               enable    = 1'b0;
               m_en      = 1'b0;
               m_cap     = 1'b0;
               m_left_ok = 1'b0;
               m_synced  = 1'b0;
            end else if (ev == EV_EN) begin
               enable = 1'b1;
               m_en   = 1'b1;
            end else if (ev == EV_RST) begin
               rst_n = 1'b0;
               #25;
               for (int i = 0; i < 3; i++) begin
                  check("rst_mid_valid", valid[i], 0);
                  check("rst_mid_data", data_o[i], 0);
                  check("rst_mid_ferr", ferr[i], 0);
               end
               #75;
               rst_n     = 1'b1;
               used      = 100;
               m_cap     = 1'b0;
               m_left_ok = 1'b0;
               m_synced  = 1'b0;
               m_prev_ch = 1'b0;
            end
         end
         #(BCLK_HALF - used);
         bclk = 1'b1;
         tr   = $time;
         if (p == 0) begin
            if (ch != m_prev_ch && m_en) begin
               if (m_cap && !m_first_cap) ferr_q.push_back(tr + LAT);
               if (m_cap && m_cap_ch) m_left_ok = 1'b0;
               m_cap       = 1'b1;
               m_cap_ch    = ch;
               m_first_cap = !m_synced;
               m_synced    = 1'b1;
               started     = 1'b1;
            end
            m_prev_ch = ch;
         end
         if (p == DW && started && m_cap) begin
            m_cap = 1'b0;
            if (!ch) begin
               push_exp(0, d, tr + LAT);
               m_left_q  = d;
               m_left_ok = 1'b1;
            end else begin
               push_exp(1, d, tr + LAT);
               if (m_left_ok) push_exp(2, mix_ref(m_left_q, d), tr + LAT);
               m_left_ok = 1'b0;
            end
         end
         #(BCLK_HALF);
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
      send_slot(1'b0, 31, l, EV_NONE, -1);
      send_slot(1'b1, 31, r, EV_NONE, -1);
   endtask

   // Monitor: compares every output pulse against the scoreboard, including arrival time.
   initial begin
      exp_t e;
      logic exp_fe;
      forever begin
         @(negedge audio_clk);
         for (int i = 0; i < 3; i++) begin
            while (exp_q[i].size() > 0 && exp_q[i][0].t < $time) begin
               checks++;
               errors++;
               $display("FAIL missing_valid sel=%0d actual=none expected=%06h at %0t",
                        i, exp_q[i][0].d, exp_q[i][0].t);
               void'(exp_q[i].pop_front());
            end
            if (valid[i]) begin
               if (exp_q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid sel=%0d actual=%06h expected=none at %0t",
                           i, data_o[i], $time);
               end else begin
                  e = exp_q[i].pop_front();
                  $display("tx sel=%0d data=%06h t=%0t", i, data_o[i], $time);
                  check($sformatf("data_sel%0d", i), data_o[i], e.d);
                  check($sformatf("time_sel%0d", i), $time, e.t);
               end
            end
         end
         while (ferr_q.size() > 0 && ferr_q[0] < $time) begin
            checks++;
            errors++;
            $display("FAIL missing_frame_err actual=none expected=1 at %0t", ferr_q[0]);
            void'(ferr_q.pop_front());
         end
         exp_fe = (ferr_q.size() > 0 && ferr_q[0] == $time);
         if (exp_fe || (|ferr)) begin
            $display("tx frame_err=%b expected=%b t=%0t", ferr, exp_fe, $time);
            for (int i = 0; i < 3; i++) check($sformatf("frame_err_sel%0d", i), ferr[i], exp_fe);
            if (exp_fe) void'(ferr_q.pop_front());
         end
      end
   end

   initial begin
      m_prev_ch = 0; m_en = 1; m_cap = 0; m_cap_ch = 0;
      m_first_cap = 0; m_synced = 0; m_left_ok = 0; m_left_q = '0;
      rst_n  = 1'b0;
      enable = 1'b1;
      repeat (2) @(negedge audio_clk);
      for (int i = 0; i < 3; i++) begin
         check("reset_valid", valid[i], 0);
         check("reset_data", data_o[i], 0);
         check("reset_ferr", ferr[i], 0);
      end
      rst_n = 1'b1;
      @(negedge audio_clk);

      send_slot(1'b1, 31, 24'($urandom), EV_NONE, -1);
      send_frame(24'h123456, 24'hABCDEF);
      send_frame(24'h000010, 24'hFFFFF0);
      send_frame(24'h7FFFFF, 24'h7FFFFF);
      send_frame(24'h000003, 24'h000000);
      send_frame(24'hFFFFFD, 24'h000000);
      for (int k = 0; k < 4; k++) begin
         send_slot(1'b0, $urandom_range(24, 31), 24'($urandom), EV_NONE, -1);
         send_slot(1'b1, $urandom_range(24, 31), 24'($urandom), EV_NONE, -1);
      end
      send_slot(1'b0, 16, 24'($urandom), EV_NONE, -1);
      send_slot(1'b1, 31, 24'($urandom), EV_NONE, -1);
      send_frame(24'($urandom), 24'($urandom));
      send_slot(1'b0, 31, 24'($urandom), EV_DIS, 10);
      send_slot(1'b1, 31, 24'($urandom), EV_EN, 12);
      send_frame(24'($urandom), 24'($urandom));
      send_frame(24'($urandom), 24'($urandom));
      send_slot(1'b0, 31, 24'($urandom), EV_RST, 8);
      send_slot(1'b1, 31, 24'($urandom), EV_NONE, -1);
      send_frame(24'($urandom), 24'($urandom));
      for (int k = 0; k < 256; k++) send_frame(24'(k), 24'($urandom));
      send_slot(1'b0, 31, 24'($urandom), EV_NONE, -1);
      bclk = 1'b0;
      #2000;

      for (int i = 0; i < 3; i++) check($sformatf("leftover_sel%0d", i), exp_q[i].size(), 0);
      check("leftover_frame_err", ferr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
